i2c_master_fsm: RTL and testbench



---
 rtl/i2c_pkg.sv | 32 +++
 rtl/i2c_master_fsm_if.sv | 35 +++
 rtl/i2c_clk_edge.sv | 24 ++
 rtl/i2c_master_fsm.sv | 203 ++++++++++++++++++++
 tb/tb_i2c_master_fsm.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the byte-level I2C master.
//   i2c_state_t   - master FSM state encoding
//   ADDR_W_DEF    - default slave address width
//   DATA_W_DEF    - default data byte width
//   RW_WRITE/READ - values of the R/W bit
//   cnt_w()       - bit counter width, wide enough for ADDR_W and DATA_W-1
package i2c_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 8;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    ACK_ADDR,
    WR,
    ACK_WR,
    RD,
    MACK,
    STOP
  } i2c_state_t;

  // The address phase counts ADDR_W..0 (address plus R/W), data counts DATA_W-1..0.
  function automatic int cnt_w(input int aw, input int dw);
    return $clog2(((aw + 1) > dw) ? (aw + 1) : dw);
  endfunction

endpackage

// File: rtl/i2c_master_fsm_if.sv
// i2c_master_fsm_if: host command and SDA/SCL-stage signals of the I2C master.
//   master modport - the FSM: takes data_clk, host command and sampled SDA,
//                    returns sda_oe, scl_not_ena and host status.
//   slave modport  - the surrounding logic (host, stretch stage, pad).
interface i2c_master_fsm_if
  import i2c_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              data_clk;
  logic              ena;
  logic [ADDR_W-1:0] addr;
  logic              rw;
  logic [DATA_W-1:0] data_wr;
  logic              sda_in;
  logic              sda_oe;
  logic              scl_not_ena;
  logic              busy;
  logic              req_next;
  logic [DATA_W-1:0] data_rd;
  logic              ack_error;

  modport master (
    input  data_clk, ena, addr, rw, data_wr, sda_in,
    output sda_oe, scl_not_ena, busy, req_next, data_rd, ack_error
  );

  modport slave (
    output data_clk, ena, addr, rw, data_wr, sda_in,
    input  sda_oe, scl_not_ena, busy, req_next, data_rd, ack_error
  );

endinterface

// File: rtl/i2c_clk_edge.sv
// i2c_clk_edge: rise/fall pulse generator for the data_clk phase clock.
//   clk        - system clock
//   i_data_clk - phase clock, already registered in the clk domain
//   o_rise     - one-cycle pulse on a 0->1 transition
//   o_fall     - one-cycle pulse on a 1->0 transition
module i2c_clk_edge (
  input  logic clk,
  input  logic i_data_clk,
  output logic o_rise,
  output logic o_fall
);

  logic r_dclk_q;

  // Tracks data_clk even through reset so that releasing reset while
  // data_clk is high does not produce a spurious rise.
  always_ff @(posedge clk) begin
    r_dclk_q <= i_data_clk;
  end

  assign o_rise = i_data_clk & ~r_dclk_q;
  assign o_fall = ~i_data_clk & r_dclk_q;

endmodule

// File: rtl/i2c_master_fsm.sv
// i2c_master_fsm: byte-level I2C master sequencer driven by the data_clk phase.
//   clk, rst - system clock, synchronous active-high reset
//   bus      - i2c_master_fsm_if.master: data_clk/ena/addr/rw/data_wr/sda_in in,
//              sda_oe/scl_not_ena/busy/req_next/data_rd/ack_error out
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | bus free, waiting for ena on a data_clk rise
// START    | START held; also repeated START (SDA high one cycle first)
// ADDR     | shifting address + R/W, MSB first
// ACK_ADDR | SDA released, slave acknowledges address
// WR       | shifting write byte, MSB first
// ACK_WR   | SDA released, slave acknowledges byte; host decides next
// RD       | SDA released, sampling read byte on falls
// MACK     | master ACK (continue) or NACK (last byte); host decides next
// STOP     | SDA low with SCL idle, then release for STOP
module i2c_master_fsm
  import i2c_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic              clk,
  input logic              rst,
  i2c_master_fsm_if.master bus
);

  localparam int CNT_W = cnt_w(ADDR_W, DATA_W);

  logic w_rise, w_fall;

  i2c_clk_edge u_edge (
    .clk       (clk),
    .i_data_clk(bus.data_clk),
    .o_rise    (w_rise),
    .o_fall    (w_fall)
  );

  i2c_state_t        r_state,     w_state;
  logic              r_sda_oe,    w_sda_oe;
  logic              r_scl_ne,    w_scl_ne;
  logic              r_busy,      w_busy;
  logic              r_req_next,  w_req_next;
  logic [DATA_W-1:0] r_data_rd,   w_data_rd;
  logic              r_ack_error, w_ack_error;
  logic [CNT_W-1:0]  r_bit_cnt,   w_bit_cnt;
  logic [ADDR_W:0]   r_addr_rw,   w_addr_rw;
  logic [DATA_W-1:0] r_tx,        w_tx;
  logic [DATA_W-1:0] r_rx,        w_rx;
  logic              r_rstart,    w_rstart;

  logic [CNT_W-1:0]  w_cnt_dec;
  logic              w_same;

  assign w_cnt_dec = r_bit_cnt - CNT_W'(1);
  assign w_same    = ({bus.addr, bus.rw} == r_addr_rw);

  always_comb begin
    w_state     = r_state;
    w_sda_oe    = r_sda_oe;
    w_scl_ne    = r_scl_ne;
    w_busy      = r_busy;
    w_req_next  = 1'b0;
    w_data_rd   = r_data_rd;
    w_ack_error = r_ack_error;
    w_bit_cnt   = r_bit_cnt;
    w_addr_rw   = r_addr_rw;
    w_tx        = r_tx;
    w_rx        = r_rx;
    w_rstart    = r_rstart;

    if (w_rise) begin
      case (r_state)
        IDLE: if (bus.ena) begin
          w_addr_rw = {bus.addr, bus.rw};
          w_tx      = bus.data_wr;
          w_busy    = 1'b1;
          w_sda_oe  = 1'b1;
          w_state   = START;
        end
        START: if (r_rstart) begin
          // SDA has been high for a full data_clk cycle: pull it low now.
          w_rstart  = 1'b0;
          w_sda_oe  = 1'b1;
          w_addr_rw = {bus.addr, bus.rw};
          w_tx      = bus.data_wr;
        end else begin
          w_sda_oe  = ~r_addr_rw[ADDR_W];
          w_bit_cnt = CNT_W'(ADDR_W);
          w_state   = ADDR;
        end
        ADDR: if (r_bit_cnt == '0) begin
          w_sda_oe = 1'b0;
          w_state  = ACK_ADDR;
        end else begin
          w_bit_cnt = w_cnt_dec;
          w_sda_oe  = ~r_addr_rw[w_cnt_dec];
        end
        ACK_ADDR: begin
          w_bit_cnt = CNT_W'(DATA_W - 1);
          if (r_addr_rw[0] == RW_READ) begin
            w_sda_oe = 1'b0;
            w_state  = RD;
          end else begin
            w_sda_oe = ~r_tx[DATA_W-1];
            w_state  = WR;
          end
        end
        WR: if (r_bit_cnt == '0) begin
          w_sda_oe = 1'b0;
          w_state  = ACK_WR;
        end else begin
          w_bit_cnt = w_cnt_dec;
          w_sda_oe  = ~r_tx[w_cnt_dec];
        end
        RD: if (r_bit_cnt == '0) begin
          w_data_rd = r_rx;
          // ACK only if the host will continue reading from the same slave.
          w_sda_oe  = bus.ena && w_same;
          w_state   = MACK;
        end else begin
          w_bit_cnt = w_cnt_dec;
        end
        ACK_WR, MACK: begin
          if (bus.ena && w_same) begin
            w_req_next = 1'b1;
            w_tx       = bus.data_wr;
            w_bit_cnt  = CNT_W'(DATA_W - 1);
            if (r_addr_rw[0] == RW_WRITE) begin
              w_sda_oe = ~bus.data_wr[DATA_W-1];
              w_state  = WR;
            end else begin
              w_sda_oe = 1'b0;
              w_state  = RD;
            end
          end else if (bus.ena) begin
            w_sda_oe = 1'b0;
            w_rstart = 1'b1;
            w_state  = START;
          end else begin
            w_sda_oe = 1'b1;
            w_state  = STOP;
          end
        end
        STOP: begin
          w_sda_oe = 1'b0;
          w_busy   = 1'b0;
          w_state  = IDLE;
        end
        default: w_state = IDLE;
      endcase
    end else if (w_fall) begin
      case (r_state)
        START: begin
          w_scl_ne    = 1'b0;
          w_ack_error = 1'b0;
        end
        ACK_ADDR, ACK_WR: w_ack_error = r_ack_error | bus.sda_in;
        RD:               w_rx[r_bit_cnt] = bus.sda_in;
        STOP:             w_scl_ne = 1'b1;
        default:          ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_sda_oe    <= 1'b0;
      r_scl_ne    <= 1'b1;
      r_busy      <= 1'b0;
      r_req_next  <= 1'b0;
      r_data_rd   <= '0;
      r_ack_error <= 1'b0;
      r_bit_cnt   <= CNT_W'(DATA_W - 1);
      r_addr_rw   <= '0;
      r_tx        <= '0;
      r_rx        <= '0;
      r_rstart    <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_sda_oe    <= w_sda_oe;
      r_scl_ne    <= w_scl_ne;
      r_busy      <= w_busy;
      r_req_next  <= w_req_next;
      r_data_rd   <= w_data_rd;
      r_ack_error <= w_ack_error;
      r_bit_cnt   <= w_bit_cnt;
      r_addr_rw   <= w_addr_rw;
      r_tx        <= w_tx;
      r_rx        <= w_rx;
      r_rstart    <= w_rstart;
    end
  end

  assign bus.sda_oe      = r_sda_oe;
  assign bus.scl_not_ena = r_scl_ne;
  assign bus.busy        = r_busy;
  assign bus.req_next    = r_req_next;
  assign bus.data_rd     = r_data_rd;
  assign bus.ack_error   = r_ack_error;

endmodule

// File: tb/tb_i2c_master_fsm.sv
// tb_i2c_master_fsm: directed bench for i2c_master_fsm. The bench generates
// data_clk, plays the slave on sda_in and records sda_oe after every rise.
module tb_i2c_master_fsm;
  import i2c_pkg::*;

  localparam int HALF = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  i2c_master_fsm_if #(.ADDR_W(7), .DATA_W(8)) bus ();

  i2c_master_fsm #(.ADDR_W(7), .DATA_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  int   req_seen = 0;
  logic oe_q[$];
  logic exp_q[$];

  // One data_clk period: rise (sda_oe recorded), then fall with sda_in=sin.
  task automatic step(input logic sin);
    @(negedge clk);
    bus.data_clk = 1'b1;
    repeat (HALF) begin
      @(negedge clk);
      if (bus.req_next) req_seen++;
    end
    oe_q.push_back(bus.sda_oe);
    bus.sda_in   = sin;
    bus.data_clk = 1'b0;
    repeat (HALF) begin
      @(negedge clk);
      if (bus.req_next) req_seen++;
    end
  endtask

  // Eight address bits, then the ACK slot with the slave answering ack.
  task automatic addr_phase(input logic ack);
    repeat (8) step(1'b1);
    step(ack);
  endtask

  task automatic wr_byte(input logic ack);
    repeat (8) step(1'b1);
    step(ack);
  endtask

  task automatic rd_byte(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) step(d[i]);
  endtask

  task automatic exp_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) exp_q.push_back(~b[i]);
  endtask

  task automatic exp_bits(input logic v, input int n);
    repeat (n) exp_q.push_back(v);
  endtask

  task automatic new_test();
    oe_q.delete();
    exp_q.delete();
    req_seen = 0;
  endtask

  task automatic test_reset();
    new_test();
    repeat (4) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({bus.sda_oe, bus.scl_not_ena, bus.busy, bus.req_next, bus.ack_error} !== 5'b01000) begin
      failures++;
      $display("FAIL reset_ctrl got oe/scl/busy/req/ack=%b exp 01000",
               {bus.sda_oe, bus.scl_not_ena, bus.busy, bus.req_next, bus.ack_error});
    end
    checks++;
    if (bus.data_rd !== 8'h00) begin
      failures++;
      $display("FAIL reset_data_rd got %h exp 00", bus.data_rd);
    end
    bus.ena = 1'b0;
    step(1'b1);
    step(1'b1);
    checks++;
    if (bus.busy !== 1'b0 || oe_q[0] !== 1'b0 || oe_q[1] !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_ena got busy=%b oe=%b%b exp busy=0 oe=00", bus.busy, oe_q[0], oe_q[1]);
    end
  endtask

  task automatic test_write();
    new_test();
    bus.addr = 7'h50; bus.rw = RW_WRITE; bus.data_wr = 8'hA5; bus.ena = 1'b1;
    exp_bits(1'b1, 1); exp_byte(8'hA0); exp_bits(1'b0, 1);
    exp_byte(8'hA5); exp_bits(1'b0, 1); exp_bits(1'b1, 1); exp_bits(1'b0, 1);
    step(1'b1);
    checks++;
    if (bus.busy !== 1'b1 || bus.scl_not_ena !== 1'b0) begin
      failures++;
      $display("FAIL wr_start got busy=%b scl_ne=%b exp 1 0", bus.busy, bus.scl_not_ena);
    end
    bus.ena = 1'b0;
    addr_phase(1'b0);
    wr_byte(1'b0);
    step(1'b1);
    checks++;
    if (bus.scl_not_ena !== 1'b1 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL wr_stop got scl_ne=%b busy=%b exp 1 1", bus.scl_not_ena, bus.busy);
    end
    step(1'b1);
    foreach (exp_q[i]) begin
      checks++;
      if (i >= oe_q.size() || oe_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL wr_sda_oe step %0d got %b exp %b", i + 1, (i < oe_q.size()) ? oe_q[i] : 1'bx, exp_q[i]);
      end
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.ack_error !== 1'b0 || req_seen !== 0) begin
      failures++;
      $display("FAIL wr_end got busy=%b ack_err=%b req=%0d exp 0 0 0", bus.busy, bus.ack_error, req_seen);
    end
  endtask

  task automatic test_read();
    new_test();
    bus.addr = 7'h3C; bus.rw = RW_READ; bus.ena = 1'b1;
    exp_bits(1'b1, 1); exp_byte(8'h79); exp_bits(1'b0, 1);
    exp_bits(1'b0, 8); exp_bits(1'b0, 1); exp_bits(1'b1, 1); exp_bits(1'b0, 1);
    step(1'b1);
    addr_phase(1'b0);
    rd_byte(8'h5A);
    bus.ena = 1'b0;
    step(1'b1);
    checks++;
    if (bus.data_rd !== 8'h5A) begin
      failures++;
      $display("FAIL rd_data got %h exp 5a", bus.data_rd);
    end
    step(1'b1);
    step(1'b1);
    foreach (exp_q[i]) begin
      checks++;
      if (i >= oe_q.size() || oe_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL rd_sda_oe step %0d got %b exp %b", i + 1, (i < oe_q.size()) ? oe_q[i] : 1'bx, exp_q[i]);
      end
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.scl_not_ena !== 1'b1) begin
      failures++;
      $display("FAIL rd_end got busy=%b scl_ne=%b exp 0 1", bus.busy, bus.scl_not_ena);
    end
  endtask

  task automatic test_nack();
    new_test();
    bus.addr = 7'h50; bus.rw = RW_WRITE; bus.data_wr = 8'hFF; bus.ena = 1'b1;
    step(1'b1);
    addr_phase(1'b1);
    checks++;
    if (bus.ack_error !== 1'b1) begin
      failures++;
      $display("FAIL nack_addr got ack_err=%b exp 1", bus.ack_error);
    end
    bus.ena = 1'b0;
    wr_byte(1'b1);
    step(1'b1);
    step(1'b1);
    checks++;
    if (bus.ack_error !== 1'b1 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL nack_sticky got ack_err=%b busy=%b exp 1 0", bus.ack_error, bus.busy);
    end
    bus.ena = 1'b1;
    step(1'b1);
    checks++;
    if (bus.ack_error !== 1'b0) begin
      failures++;
      $display("FAIL nack_clear got ack_err=%b exp 0", bus.ack_error);
    end
    bus.ena = 1'b0;
    addr_phase(1'b0);
    checks++;
    if (bus.ack_error !== 1'b0) begin
      failures++;
      $display("FAIL nack_addr_ok got ack_err=%b exp 0", bus.ack_error);
    end
    wr_byte(1'b1);
    checks++;
    if (bus.ack_error !== 1'b1) begin
      failures++;
      $display("FAIL nack_data got ack_err=%b exp 1", bus.ack_error);
    end
    step(1'b1);
    step(1'b1);
  endtask

  task automatic test_back_to_back();
    new_test();
    bus.addr = 7'h2A; bus.rw = RW_WRITE; bus.data_wr = 8'h11; bus.ena = 1'b1;
    exp_bits(1'b1, 1); exp_byte(8'h54); exp_bits(1'b0, 1);
    exp_byte(8'h11); exp_bits(1'b0, 1);
    exp_byte(8'h22); exp_bits(1'b0, 1); exp_bits(1'b1, 1); exp_bits(1'b0, 1);
    step(1'b1);
    addr_phase(1'b0);
    wr_byte(1'b0);
    bus.data_wr = 8'h22;
    wr_byte(1'b0);
    checks++;
    if (bus.busy !== 1'b1 || bus.scl_not_ena !== 1'b0 || req_seen !== 1) begin
      failures++;
      $display("FAIL b2b_between got busy=%b scl_ne=%b req=%0d exp 1 0 1", bus.busy, bus.scl_not_ena, req_seen);
    end
    bus.ena = 1'b0;
    step(1'b1);
    step(1'b1);
    foreach (exp_q[i]) begin
      checks++;
      if (i >= oe_q.size() || oe_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL b2b_sda_oe step %0d got %b exp %b", i + 1, (i < oe_q.size()) ? oe_q[i] : 1'bx, exp_q[i]);
      end
    end
    checks++;
    if (req_seen !== 1 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end got req=%0d busy=%b exp 1 0", req_seen, bus.busy);
    end
  endtask

  task automatic test_rstart();
    new_test();
    bus.addr = 7'h50; bus.rw = RW_WRITE; bus.data_wr = 8'hC3; bus.ena = 1'b1;
    exp_bits(1'b1, 1); exp_byte(8'hA0); exp_bits(1'b0, 1);
    exp_byte(8'hC3); exp_bits(1'b0, 1);
    exp_bits(1'b0, 1); exp_bits(1'b1, 1);
    exp_byte(8'hA1); exp_bits(1'b0, 1);
    exp_bits(1'b0, 8); exp_bits(1'b0, 1); exp_bits(1'b1, 1); exp_bits(1'b0, 1);
    step(1'b1);
    addr_phase(1'b0);
    wr_byte(1'b0);
    bus.rw = RW_READ;
    step(1'b1);
    checks++;
    if (bus.scl_not_ena !== 1'b0 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL rs_release got scl_ne=%b busy=%b exp 0 1", bus.scl_not_ena, bus.busy);
    end
    step(1'b1);
    checks++;
    if (bus.scl_not_ena !== 1'b0 || bus.sda_oe !== 1'b1) begin
      failures++;
      $display("FAIL rs_start got scl_ne=%b oe=%b exp 0 1", bus.scl_not_ena, bus.sda_oe);
    end
    addr_phase(1'b0);
    rd_byte(8'h96);
    bus.ena = 1'b0;
    step(1'b1);
    step(1'b1);
    step(1'b1);
    foreach (exp_q[i]) begin
      checks++;
      if (i >= oe_q.size() || oe_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL rs_sda_oe step %0d got %b exp %b", i + 1, (i < oe_q.size()) ? oe_q[i] : 1'bx, exp_q[i]);
      end
    end
    checks++;
    if (bus.data_rd !== 8'h96 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL rs_end got data_rd=%h busy=%b exp 96 0", bus.data_rd, bus.busy);
    end
  endtask

  task automatic test_mid_reset();
    new_test();
    bus.addr = 7'h50; bus.rw = RW_WRITE; bus.data_wr = 8'hA5; bus.ena = 1'b1;
    step(1'b1);
    addr_phase(1'b0);
    repeat (3) step(1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({bus.sda_oe, bus.scl_not_ena, bus.busy, bus.req_next} !== 4'b0100) begin
      failures++;
      $display("FAIL mrst_ctrl got oe/scl/busy/req=%b exp 0100",
               {bus.sda_oe, bus.scl_not_ena, bus.busy, bus.req_next});
    end
    checks++;
    if (bus.data_rd !== 8'h00) begin
      failures++;
      $display("FAIL mrst_data_rd got %h exp 00", bus.data_rd);
    end
    new_test();
    exp_bits(1'b1, 1); exp_byte(8'hA0); exp_bits(1'b0, 1);
    exp_byte(8'hA5); exp_bits(1'b0, 1); exp_bits(1'b1, 1); exp_bits(1'b0, 1);
    step(1'b1);
    bus.ena = 1'b0;
    addr_phase(1'b0);
    wr_byte(1'b0);
    step(1'b1);
    step(1'b1);
    foreach (exp_q[i]) begin
      checks++;
      if (i >= oe_q.size() || oe_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL mrst_sda_oe step %0d got %b exp %b", i + 1, (i < oe_q.size()) ? oe_q[i] : 1'bx, exp_q[i]);
      end
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.scl_not_ena !== 1'b1 || bus.ack_error !== 1'b0) begin
      failures++;
      $display("FAIL mrst_end got busy=%b scl_ne=%b ack_err=%b exp 0 1 0", bus.busy, bus.scl_not_ena, bus.ack_error);
    end
  endtask

  initial begin
    bus.data_clk = 1'b0;
    bus.ena      = 1'b0;
    bus.addr     = '0;
    bus.rw       = 1'b0;
    bus.data_wr  = '0;
    bus.sda_in   = 1'b1;
    test_reset();
    test_write();
    test_read();
    test_nack();
    test_back_to_back();
    test_rstart();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
